// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : axis_arb_pkg
// Brief  : Shared types and constants for the AXI-Stream pipeline arbiter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package axis_arb_pkg;

   localparam int unsigned c_data_w = 16;
   localparam int unsigned c_cnt_w  = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef logic tag_t;

   // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last.
   function automatic tag_t rr_pick(input logic v0, input logic v1, input tag_t last);
      if (v0 && v1) begin
         return ~last;
      end
      return tag_t'(v1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tag_fifo
// Brief  : Synchronous DEPTH x 1 FIFO holding the requester tag of each beat.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tag_fifo
   import axis_arb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t pop_tag,
   output logic full,
   output logic empty
);

   localparam int c_aw = $clog2(DEPTH);

   logic [c_aw:0]    r_wptr;
   logic [c_aw:0]    r_rptr;
   logic [DEPTH-1:0] r_mem;
   logic [c_aw:0]    w_count;

   // Extra wrap bit lets the pointer difference span 0..DEPTH inclusive.
   assign w_count = r_wptr - r_rptr;
   assign full    = (w_count == (c_aw+1)'(DEPTH));
   assign empty   = (w_count == '0);
   assign pop_tag = r_mem[r_rptr[c_aw-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_mem  <= '0;
      end else begin
         if (push && !full) begin
            r_mem[r_wptr[c_aw-1:0]] <= push_tag;
            r_wptr                  <= r_wptr + 1'b1;
         end
         if (pop && !empty) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_pipeline_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : axis_pipeline_arbiter
// Brief  : Round-robin packet arbiter sharing one stream pipeline between two
//          requesters, with tag-based routing of results back to each side.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module axis_pipeline_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DATA_W    = c_data_w,
   parameter int TAG_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic              s0_tvalid,
   input  logic              s0_tlast,
   output logic              s0_tready,
   input  logic [DATA_W-1:0] s1_tdata,
   input  logic              s1_tvalid,
   input  logic              s1_tlast,
   output logic              s1_tready,
   output logic [DATA_W-1:0] pipe_in_tdata,
   output logic              pipe_in_tvalid,
   output logic              pipe_in_tlast,
   input  logic              pipe_in_tready,
   input  logic [DATA_W-1:0] pipe_out_tdata,
   input  logic              pipe_out_tvalid,
   input  logic              pipe_out_tlast,
   output logic              pipe_out_tready,
   output logic [DATA_W-1:0] m0_tdata,
   output logic              m0_tvalid,
   output logic              m0_tlast,
   input  logic              m0_tready,
   output logic [DATA_W-1:0] m1_tdata,
   output logic              m1_tvalid,
   output logic              m1_tlast,
   input  logic              m1_tready,
   output logic [c_cnt_w-1:0] beats0,
   output logic [c_cnt_w-1:0] beats1,
   output logic              err
);

   localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

   arb_state_t         r_state;
   tag_t               r_grant;
   tag_t               r_last;
   logic [c_cnt_w-1:0] r_beats0;
   logic [c_cnt_w-1:0] r_beats1;
   logic               r_err;

   logic w_active, w_full, w_empty, w_in_hs, w_pop;
   logic w_sel_valid, w_sel_last, w_out_to0, w_out_to1;
   logic [DATA_W-1:0] w_sel_data;
   tag_t w_head;

   assign w_active    = (r_state == GRANT);
   assign w_sel_valid = r_grant ? s1_tvalid : s0_tvalid;
   assign w_sel_last  = r_grant ? s1_tlast  : s0_tlast;
   assign w_sel_data  = r_grant ? s1_tdata  : s0_tdata;

   assign pipe_in_tvalid = w_active && w_sel_valid && !w_full;
   assign pipe_in_tdata  = w_active ? w_sel_data : '0;
   assign pipe_in_tlast  = w_active && w_sel_last;
   assign s0_tready      = w_active && !r_grant && pipe_in_tready && !w_full;
   assign s1_tready      = w_active &&  r_grant && pipe_in_tready && !w_full;
   assign w_in_hs        = pipe_in_tvalid && pipe_in_tready;

   // Results route by the oldest outstanding tag; with none outstanding the beat is sunk.
   assign w_out_to0 = !w_empty && !w_head;
   assign w_out_to1 = !w_empty &&  w_head;
   assign m0_tvalid = pipe_out_tvalid && w_out_to0;
   assign m1_tvalid = pipe_out_tvalid && w_out_to1;
   assign m0_tdata  = w_out_to0 ? pipe_out_tdata : '0;
   assign m1_tdata  = w_out_to1 ? pipe_out_tdata : '0;
   assign m0_tlast  = w_out_to0 && pipe_out_tlast;
   assign m1_tlast  = w_out_to1 && pipe_out_tlast;
   assign pipe_out_tready = w_empty ? pipe_out_tvalid : (w_head ? m1_tready : m0_tready);
   assign w_pop     = pipe_out_tvalid && pipe_out_tready && !w_empty;

   assign beats0 = r_beats0;
   assign beats1 = r_beats1;
   assign err    = r_err;

   tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (w_in_hs),
      .push_tag (r_grant),
      .pop      (w_pop),
      .pop_tag  (w_head),
      .full     (w_full),
      .empty    (w_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_grant  <= 1'b0;
         r_last   <= 1'b1;
         r_beats0 <= '0;
         r_beats1 <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s0_tvalid || s1_tvalid) begin
                  r_grant <= rr_pick(s0_tvalid, s1_tvalid, r_last);
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (w_in_hs && pipe_in_tlast) begin
                  r_last  <= r_grant;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_in_hs) begin
            if (r_grant) r_beats1 <= r_beats1 + c_one;
            else         r_beats0 <= r_beats0 + c_one;
         end
         if (pipe_out_tvalid && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_pipeline_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_axis_pipeline_arbiter
// Brief  : Scoreboard bench with a +1 pipeline model for axis_pipeline_arbiter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_axis_pipeline_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] s0_tdata = '0, s1_tdata = '0;
   logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
   logic        s0_tready, s1_tready;
   logic [15:0] pipe_in_tdata;
   logic        pipe_in_tvalid, pipe_in_tlast;
   logic        pipe_in_tready = 1'b1;
   logic [15:0] pipe_out_tdata = '0;
   logic        pm_valid = 1'b0, inject = 1'b0, pipe_out_tlast = 1'b0;
   logic        pipe_out_tvalid, pipe_out_tready;
   logic [15:0] m0_tdata, m1_tdata;
   logic        m0_tvalid, m0_tlast, m1_tvalid, m1_tlast;
   logic        m0_tready = 1'b1, m1_tready = 1'b1;
   logic [31:0] beats0, beats1;
   logic        err;

   assign pipe_out_tvalid = pm_valid | inject;

   axis_pipeline_arbiter #(.DATA_W(16), .TAG_DEPTH(8)) dut (
      .clock(clk), .reset(rst),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
      .pipe_in_tdata(pipe_in_tdata), .pipe_in_tvalid(pipe_in_tvalid),
      .pipe_in_tlast(pipe_in_tlast), .pipe_in_tready(pipe_in_tready),
      .pipe_out_tdata(pipe_out_tdata), .pipe_out_tvalid(pipe_out_tvalid),
      .pipe_out_tlast(pipe_out_tlast), .pipe_out_tready(pipe_out_tready),
      .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tlast(m0_tlast), .m0_tready(m0_tready),
      .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tlast(m1_tlast), .m1_tready(m1_tready),
      .beats0(beats0), .beats1(beats1), .err(err)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {tlast, tdata} entries
   logic [16:0] src0_q[$], src1_q[$], pq[$], exp0[$], exp1[$];
   logic [15:0] pin_log[$];
   int          src_log[$], cyc_log[$];
   int          cyc = 0, m0_count = 0, m1_count = 0;
   logic        hs_s0 = 0, hs_s1 = 0, hs_pin = 0, hs_pout = 0, pin_last_c = 0;
   logic [15:0] pin_data_c = '0;

   // Monitor and scoreboard compare, away from the active edge.
   always @(negedge clk) begin
      logic [16:0] e;
      logic [15:0] d;
      hs_s0      = s0_tvalid && s0_tready;
      hs_s1      = s1_tvalid && s1_tready;
      hs_pin     = pipe_in_tvalid && pipe_in_tready;
      hs_pout    = pipe_out_tvalid && pipe_out_tready;
      pin_data_c = pipe_in_tdata;
      pin_last_c = pipe_in_tlast;
      if (rst) begin
         hs_s0 = 0; hs_s1 = 0; hs_pin = 0; hs_pout = 0;
      end else begin
         cyc++;
         if (hs_s0) begin d = s0_tdata + 16'd1; exp0.push_back({s0_tlast, d}); end
         if (hs_s1) begin d = s1_tdata + 16'd1; exp1.push_back({s1_tlast, d}); end
         if (hs_pin) begin
            pin_log.push_back(pipe_in_tdata);
            cyc_log.push_back(cyc);
            src_log.push_back(hs_s1 ? 1 : 0);
         end
         if (m0_tvalid && m0_tready) begin
            m0_count++;
            if (exp0.size() == 0) check("m0 unexpected beat", 32'd1, 32'd0);
            else begin
               e = exp0.pop_front();
               check("m0 data", 32'(m0_tdata), 32'(e[15:0]));
               check("m0 last", 32'(m0_tlast), 32'(e[16]));
            end
         end
         if (m1_tvalid && m1_tready) begin
            m1_count++;
            if (exp1.size() == 0) check("m1 unexpected beat", 32'd1, 32'd0);
            else begin
               e = exp1.pop_front();
               check("m1 data", 32'(m1_tdata), 32'(e[15:0]));
               check("m1 last", 32'(m1_tlast), 32'(e[16]));
            end
         end
      end
   end

   // Source drivers and a +1 pipeline model with 16 entries of buffering.
   always @(posedge clk) begin
      logic [15:0] pd;
      #1;
      if (rst) pq.delete();
      else begin
         if (hs_pout && pq.size() > 0) void'(pq.pop_front());
         if (hs_pin) begin pd = pin_data_c + 16'd1; pq.push_back({pin_last_c, pd}); end
      end
      if (hs_s0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (hs_s1 && src1_q.size() > 0) void'(src1_q.pop_front());
      s0_tvalid = (src0_q.size() > 0);
      {s0_tlast, s0_tdata} = s0_tvalid ? src0_q[0] : 17'd0;
      s1_tvalid = (src1_q.size() > 0);
      {s1_tlast, s1_tdata} = s1_tvalid ? src1_q[0] : 17'd0;
      pm_valid = (pq.size() > 0);
      {pipe_out_tlast, pipe_out_tdata} = pm_valid ? pq[0] : 17'd0;
      pipe_in_tready = (pq.size() < 16);
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic clear_logs();
      pin_log.delete(); src_log.delete(); cyc_log.delete();
      m0_count = 0; m1_count = 0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 300; i++) begin
         if (src0_q.size() == 0 && src1_q.size() == 0 && exp0.size() == 0 &&
             exp1.size() == 0 && pq.size() == 0) begin
            done = 1;
            break;
         end
         step();
      end
      if (!done) check("drain timeout", 32'd0, 32'd1);
      step(2);
   endtask

   initial begin
      step(3);
      check("rst s0_tready", 32'(s0_tready), 0);
      check("rst s1_tready", 32'(s1_tready), 0);
      check("rst pipe_in_tvalid", 32'(pipe_in_tvalid), 0);
      check("rst pipe_in_tdata", 32'(pipe_in_tdata), 0);
      check("rst pipe_out_tready", 32'(pipe_out_tready), 0);
      check("rst m0_tvalid", 32'(m0_tvalid), 0);
      check("rst m1_tvalid", 32'(m1_tvalid), 0);
      check("rst beats0", beats0, 0);
      check("rst err", 32'(err), 0);
      rst = 1'b0;

      // Single-beat packets on requester 0.
      for (int i = 0; i < 3; i++) src0_q.push_back({1'b1, 16'(i)});
      wait_idle();
      check("t1 beats0", beats0, 3);
      check("t1 beats1", beats1, 0);
      check("t1 m0 count", 32'(m0_count), 3);
      check("t1 m1 count", 32'(m1_count), 0);

      // Both requesters valid straight out of reset: requester 0 wins the tie.
      rst = 1'b1;
      exp0.delete(); exp1.delete();
      src0_q.push_back({1'b0, 16'd10}); src0_q.push_back({1'b1, 16'd11});
      src1_q.push_back({1'b0, 16'd20}); src1_q.push_back({1'b1, 16'd21});
      step();
      rst = 1'b0;
      clear_logs();
      wait_idle();
      if (pin_log.size() != 4) check("t2 pipe beats", 32'(pin_log.size()), 4);
      else begin
         check("t2 pipe[0]", 32'(pin_log[0]), 10);
         check("t2 pipe[1]", 32'(pin_log[1]), 11);
         check("t2 pipe[2]", 32'(pin_log[2]), 20);
         check("t2 pipe[3]", 32'(pin_log[3]), 21);
         check("t2 gap in pkt", 32'(cyc_log[1] - cyc_log[0]), 1);
         check("t2 idle gap", 32'(cyc_log[2] - cyc_log[1]), 2);
      end
      check("t2 beats0", beats0, 2);
      check("t2 beats1", beats1, 2);

      // Continuous contention alternates strictly.
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         src0_q.push_back({1'b1, 16'(30 + i)});
         src1_q.push_back({1'b1, 16'(40 + i)});
      end
      wait_idle();
      if (src_log.size() != 8) check("t3 pipe beats", 32'(src_log.size()), 8);
      else for (int i = 0; i < 8; i++) check("t3 order", 32'(src_log[i]), 32'(i % 2));
      check("t3 beats0", beats0, 6);
      check("t3 beats1", beats1, 6);

      // Downstream stall: only TAG_DEPTH beats in flight, data wraps 0xFFFF -> 0.
      clear_logs();
      m0_tready = 1'b0;
      for (int i = 0; i < 16; i++) src0_q.push_back({(i == 15), 16'hFFF8 + 16'(i)});
      step(20);
      check("t4 accepted", beats0, 14);
      check("t4 s0_tready", 32'(s0_tready), 0);
      check("t4 m0_tvalid", 32'(m0_tvalid), 1);
      check("t4 m1_tvalid", 32'(m1_tvalid), 0);
      m0_tready = 1'b1;
      wait_idle();
      check("t4 beats0", beats0, 22);
      check("t4 m0 count", 32'(m0_count), 16);

      // Orphan result beat sets sticky err.
      check("t5 err before", 32'(err), 0);
      inject = 1'b1;
      step();
      inject = 1'b0;
      step();
      check("t5 err set", 32'(err), 1);
      step(5);
      check("t5 err sticky", 32'(err), 1);

      // Reset mid-packet clears everything.
      for (int i = 0; i < 6; i++) src0_q.push_back({(i == 5), 16'(100 + i)});
      step(3);
      check("t6 mid-packet", 32'(pipe_in_tvalid), 1);
      rst = 1'b1;
      src0_q.delete(); exp0.delete(); exp1.delete();
      step();
      check("t6 s0_tready", 32'(s0_tready), 0);
      check("t6 pipe_in_tvalid", 32'(pipe_in_tvalid), 0);
      check("t6 pipe_in_tdata", 32'(pipe_in_tdata), 0);
      check("t6 m0_tvalid", 32'(m0_tvalid), 0);
      check("t6 beats0", beats0, 0);
      check("t6 beats1", beats1, 0);
      check("t6 err", 32'(err), 0);
      rst = 1'b0;
      step(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_pipeline_arbiter.md
# axis_pipeline_arbiter

Round-robin AXI-Stream arbiter sharing one 16-bit processing pipeline (AXI-Lite-configured, 1:1 in-order beat transform) between two requesters. Sits between two upstream stream sources and the pipeline input. A tag FIFO records which requester each beat came from, so pipeline results are routed back to the matching downstream port. Packets (tlast-delimited) are never interleaved on the pipeline input.

## Interface
- DATA_W, 16, stream data width (matches pipeline)
- TAG_DEPTH, 8, tag FIFO entries; power of 2; must be ≥ pipeline depth plus skid for full throughput
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- s0_tdata/s0_tvalid/s0_tlast/s0_tready  in/in/in/out  DATA_W/1/1/1  requester 0 input
- s1_tdata/s1_tvalid/s1_tlast/s1_tready  in/in/in/out  DATA_W/1/1/1  requester 1 input
- pipe_in_tdata/tvalid/tlast/tready  out/out/out/in  DATA_W/1/1/1  to pipeline
- pipe_out_tdata/tvalid/tlast/tready  in/in/in/out  DATA_W/1/1/1  from pipeline
- m0_tdata/tvalid/tlast/tready  out/out/out/in  DATA_W/1/1/1  results for requester 0
- m1_tdata/tvalid/tlast/tready  out/out/out/in  DATA_W/1/1/1  results for requester 1
- beats0, beats1  out  32  accepted input beats per requester, wrap 0xFFFFFFFF→0
- err  out  1  sticky: pipeline output beat arrived with tag FIFO empty

## Operation
- FSM states: IDLE, GRANT. Registers: grant (1 bit), last (1 bit, last granted).
- IDLE: if exactly one sN_tvalid, grant=N; if both, grant=!last; go GRANT next cycle. No tready asserted in IDLE.
- GRANT: pipe_in_* = s[grant]_*; s[grant]_tready = pipe_in_tready && !fifo_full; pipe_in_tvalid = s[grant]_tvalid && !fifo_full. Other sN_tready=0.
- Each accepted beat (pipe_in handshake): push grant into tag FIFO, increment beats[grant].
- Handshake with tlast=1: last←grant, go IDLE.
- Output side: head tag t selects m[t]; m[t]_tvalid = pipe_out_tvalid && !fifo_empty; pipe_out_tready = m[t]_tready when non-empty; other m port tvalid=0. Pop on handshake.
- pipe_out_tvalid with FIFO empty: pipe_out_tready=1, beat dropped, err←1 until reset.
- Push only when !full (no same-cycle pop bypass); simultaneous push+pop keeps occupancy.

## Timing
- Reset values: all tready/tvalid 0, tdata/tlast 0, state IDLE, last=1 (so requester 0 wins first tie), FIFO empty, beats0/1=0, err=0.
- Arbitration cost: one IDLE cycle per packet; beats within a packet at 1/cycle.
- Datapath through arbiter and router is combinational (0 added latency); tags registered.
- AXI-S rule: grant never changes while pipe_in_tvalid && !pipe_in_tready.
- FIFO full: input stalls; resumes cycle after a pop.
- Reset mid-packet: all state cleared in one cycle; in-flight beats in the pipeline after reset raise err if they emerge (pipeline is reset together in normal use).

## Structure
- Package axis_arb_pkg: state enum {IDLE, GRANT}, tag type (1 bit), DATA_W default, counter width 32.
- Sub-module tag_fifo: synchronous FIFO, TAG_DEPTH×1, ptrs with extra wrap bit, full/empty flags, occupancy count.

## Test plan
- Pipeline coef=1. s0 sends single-beat packets 0,1,2 (tlast each) → m0 receives 1,2,3; m1 idle; beats0=3.
- s0 and s1 both valid from reset, 2-beat packets {10,11},{20,21} → pipe sees 10,11 then 20,21 (s0 first), m0 gets 11,12, m1 gets 21,22; one IDLE cycle between packets.
- Continuous contention, 4 single-beat packets per side → strict alternation 0,1,0,1…; beats0=beats1=4.
- m0_tready=0 for 20 cycles while s0 streams 16 beats → exactly TAG_DEPTH beats accepted, s0_tready low until m0 drains; no loss, order kept 0xFFFF→0x0000 wrap in data (65535+1).
- Force pipe_out_tvalid with empty FIFO → err=1, stays 1; reset mid-packet → outputs zero next cycle, err cleared, beats0/1=0.
